// File: rtl/logic_op_pkg.sv
// Shared op-code definitions for the logic_op_pipe slice.
package logic_op_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT_A  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit bitwise logic unit, eight operations selected by op.
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y_c
);

  always_comb begin
    y_c = a;
    case (op)
      OP_AND:    y_c = a & b;
      OP_OR:     y_c = a | b;
      OP_XOR:    y_c = a ^ b;
      OP_NAND:   y_c = ~(a & b);
      OP_NOR:    y_c = ~(a | b);
      OP_XNOR:   y_c = ~(a ^ b);
      OP_NOT_A:  y_c = ~a;
      OP_PASS_A: y_c = a;
      default:   y_c = a;
    endcase
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Registered bitwise logic unit with valid/ready on both sides, 2-entry skid and
// saturating completion counter. Define LOGIC_OP_PARITY_EN to add out_parity.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OP_W-1:0]  out_op,
  output logic [CNT_W-1:0] txn_count
`ifdef LOGIC_OP_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic [WIDTH-1:0] core_y_c;
  logic             accept_c, emit_c;

  logic             main_valid, main_valid_d, skid_valid, skid_valid_d;
  logic [WIDTH-1:0] main_y, main_y_d, skid_y, skid_y_d;
  logic [OP_W-1:0]  main_op, main_op_d, skid_op, skid_op_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt, cnt_d;
`ifdef LOGIC_OP_PARITY_EN
  logic             main_par, main_par_d, skid_par, skid_par_d;
`endif

  // Results are computed before storage so both registers hold finished beats.
  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a   (in_a),
    .b   (in_b),
    .op  (in_op),
    .y_c (core_y_c)
  );

  assign accept_c = in_valid & ready_q;
  assign emit_c   = main_valid & out_ready;

  always_comb begin
    main_valid_d = main_valid;
    main_y_d     = main_y;
    main_op_d    = main_op;
    skid_valid_d = skid_valid;
    skid_y_d     = skid_y;
    skid_op_d    = skid_op;
    cnt_d        = cnt;
`ifdef LOGIC_OP_PARITY_EN
    main_par_d   = main_par;
    skid_par_d   = skid_par;
`endif
    if (emit_c) begin
      if (skid_valid) begin
        main_y_d     = skid_y;
        main_op_d    = skid_op;
        skid_valid_d = 1'b0;
`ifdef LOGIC_OP_PARITY_EN
        main_par_d   = skid_par;
`endif
      end else if (accept_c) begin
        main_y_d     = core_y_c;
        main_op_d    = in_op;
`ifdef LOGIC_OP_PARITY_EN
        main_par_d   = ^core_y_c;
`endif
      end else begin
        main_valid_d = 1'b0;
      end
      if (cnt != {CNT_W{1'b1}}) begin
        cnt_d = cnt + CNT_W'(1);
      end
    end else if (accept_c) begin
      // Main is held while stalled, so a second beat parks in the skid.
      if (!main_valid) begin
        main_valid_d = 1'b1;
        main_y_d     = core_y_c;
        main_op_d    = in_op;
`ifdef LOGIC_OP_PARITY_EN
        main_par_d   = ^core_y_c;
`endif
      end else begin
        skid_valid_d = 1'b1;
        skid_y_d     = core_y_c;
        skid_op_d    = in_op;
`ifdef LOGIC_OP_PARITY_EN
        skid_par_d   = ^core_y_c;
`endif
      end
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_y     <= '0;
      main_op    <= '0;
      skid_valid <= 1'b0;
      skid_y     <= '0;
      skid_op    <= '0;
      ready_q    <= 1'b0;
      cnt        <= '0;
`ifdef LOGIC_OP_PARITY_EN
      main_par   <= 1'b0;
      skid_par   <= 1'b0;
`endif
    end else begin
      main_valid <= main_valid_d;
      main_y     <= main_y_d;
      main_op    <= main_op_d;
      skid_valid <= skid_valid_d;
      skid_y     <= skid_y_d;
      skid_op    <= skid_op_d;
      ready_q    <= ready_d;
      cnt        <= cnt_d;
`ifdef LOGIC_OP_PARITY_EN
      main_par   <= main_par_d;
      skid_par   <= skid_par_d;
`endif
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_y     = main_y;
  assign out_op    = main_op;
  assign txn_count = cnt;
`ifdef LOGIC_OP_PARITY_EN
  assign out_parity = main_par;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: vector table, scoreboard, handshake corner cases.
module tb_logic_op_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       out_ready;

  logic        in_ready, out_valid;
  logic [7:0]  out_y;
  logic [2:0]  out_op;
  logic [15:0] txn_count;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_y;
  logic [2:0]  s_out_op;
  logic [1:0]  s_txn_count;
`ifdef LOGIC_OP_PARITY_EN
  logic        out_parity, s_out_parity;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
  } beat_t;

  vec_t  tbl [8];
  beat_t sb[$];

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_op(out_op), .txn_count(txn_count)
`ifdef LOGIC_OP_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  logic_op_pipe #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_y(s_out_y), .out_op(s_out_op), .txn_count(s_txn_count)
`ifdef LOGIC_OP_PARITY_EN
    , .out_parity(s_out_parity)
`endif
  );

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  // Scoreboard: push at the accepting edge, pop at the emitting edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra_beat: got y=%0h op=%0d with nothing outstanding", out_y, out_op);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("sb_y", 32'(out_y), 32'(e.y));
          chk("sb_op", 32'(out_op), 32'(e.op));
          chk("sat_y", 32'(s_out_y), 32'(e.y));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{ref_op(in_a, in_b, in_op), in_op});
      end
    end
  end

  initial begin
    tbl[0] = '{8'hF0, 8'h3C, 3'd0, 8'h30};
    tbl[1] = '{8'hF0, 8'h3C, 3'd1, 8'hFC};
    tbl[2] = '{8'hF0, 8'h3C, 3'd2, 8'hCC};
    tbl[3] = '{8'hF0, 8'h3C, 3'd3, 8'hCF};
    tbl[4] = '{8'hF0, 8'h3C, 3'd4, 8'h03};
    tbl[5] = '{8'hF0, 8'h3C, 3'd5, 8'h33};
    tbl[6] = '{8'hF0, 8'h3C, 3'd6, 8'h0F};
    tbl[7] = '{8'hF0, 8'h3C, 3'd7, 8'hF0};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_op", 32'(out_op), 0);
    chk("rst_txn", 32'(txn_count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
`ifdef LOGIC_OP_PARITY_EN
    chk("rst_parity", 32'(out_parity), 0);
`endif
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 1);

    // 1 + 5: back-to-back stream of all ops, saturating counter alongside
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, tbl[i].a, tbl[i].b, tbl[i].op);
      tick();
      chk("s1_valid", 32'(out_valid), 1);
      chk("s1_y", 32'(out_y), 32'(tbl[i].y));
      chk("s1_op", 32'(out_op), 32'(tbl[i].op));
      chk("s1_txn", 32'(txn_count), 32'(i));
      chk("s5_sat_txn", 32'(s_txn_count), (i < 3) ? 32'(i) : 32'd3);
    end
    set_in(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    chk("s1_txn_final", 32'(txn_count), 8);
    chk("s1_idle", 32'(out_valid), 0);
    chk("s5_sat_final", 32'(s_txn_count), 3);

    // 2: backpressure fills main then skid
    out_ready = 1'b0;
    set_in(1'b1, 8'hAA, 8'h55, 3'd2);
    tick();
    chk("s2_main_y", 32'(out_y), 32'hFF);
    chk("s2_ready_1", 32'(in_ready), 1);
    set_in(1'b1, 8'h12, 8'h34, 3'd0);
    tick();
    chk("s2_ready_0", 32'(in_ready), 0);
    chk("s2_hold_y_a", 32'(out_y), 32'hFF);
    set_in(1'b1, 8'h0F, 8'h0F, 3'd4);
    tick();
    chk("s2_ready_stay0", 32'(in_ready), 0);
    chk("s2_hold_op", 32'(out_op), 2);
    tick();
    chk("s2_hold_y_b", 32'(out_y), 32'hFF);
    set_in(1'b0, 8'h00, 8'h00, 3'd0);
    out_ready = 1'b1;
    tick();
    chk("s2_skid_y", 32'(out_y), 32'h10);
    chk("s2_skid_op", 32'(out_op), 0);
    chk("s2_ready_back", 32'(in_ready), 1);
    chk("s2_valid_skid", 32'(out_valid), 1);
    tick();
    chk("s2_drained", 32'(out_valid), 0);

    // 3: simultaneous emit and accept, skid stays empty
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
      tick();
      chk("s3_ready", 32'(in_ready), 1);
      chk("s3_valid", 32'(out_valid), 1);
    end
    set_in(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    chk("s3_idle", 32'(out_valid), 0);

    // 4: reset with main and skid full discards both
    out_ready = 1'b0;
    set_in(1'b1, 8'h5A, 8'hFF, 3'd1);
    tick();
    set_in(1'b1, 8'hC3, 8'h00, 3'd7);
    tick();
    chk("s4_full", 32'(in_ready), 0);
    set_in(1'b0, 8'h00, 8'h00, 3'd0);
    rst_n = 1'b0;
    tick();
    chk("s4_valid", 32'(out_valid), 0);
    chk("s4_txn", 32'(txn_count), 0);
    chk("s4_sat_txn", 32'(s_txn_count), 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s4_no_ghost", 32'(out_valid), 0);
    end
    chk("s4_ready", 32'(in_ready), 1);

`ifdef LOGIC_OP_PARITY_EN
    // 6: parity follows the stored result
    set_in(1'b1, 8'h07, 8'h00, 3'd1);
    tick();
    chk("s6_par_odd", 32'(out_parity), 1);
    set_in(1'b1, 8'h03, 8'h00, 3'd1);
    tick();
    chk("s6_par_even", 32'(out_parity), 0);
    set_in(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
`endif

    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
